// File: rtl/snes_joypad_pkg.sv
// Shared constants for the SNES joypad serializer: Pocket key bit positions,
// SNES serial button order and the serializer state encoding.
package snes_joypad_pkg;

   // Pocket key word bit positions
   localparam int unsigned KEY_UP     = 0;
   localparam int unsigned KEY_DOWN   = 1;
   localparam int unsigned KEY_LEFT   = 2;
   localparam int unsigned KEY_RIGHT  = 3;
   localparam int unsigned KEY_A      = 4;
   localparam int unsigned KEY_B      = 5;
   localparam int unsigned KEY_X      = 6;
   localparam int unsigned KEY_Y      = 7;
   localparam int unsigned KEY_L      = 8;
   localparam int unsigned KEY_R      = 9;
   localparam int unsigned KEY_SELECT = 14;
   localparam int unsigned KEY_START  = 15;

   // SNES serial order, first bit out is index 0
   localparam int unsigned SNES_B      = 0;
   localparam int unsigned SNES_Y      = 1;
   localparam int unsigned SNES_SELECT = 2;
   localparam int unsigned SNES_START  = 3;
   localparam int unsigned SNES_UP     = 4;
   localparam int unsigned SNES_DOWN   = 5;
   localparam int unsigned SNES_LEFT   = 6;
   localparam int unsigned SNES_RIGHT  = 7;
   localparam int unsigned SNES_A      = 8;
   localparam int unsigned SNES_X      = 9;
   localparam int unsigned SNES_L      = 10;
   localparam int unsigned SNES_R      = 11;

   localparam int unsigned SNES_SERIAL_BITS = 16;
   localparam int unsigned SNES_BUTTONS     = 12;

   typedef enum logic {
      ST_SHIFT = 1'b0,
      ST_LOAD  = 1'b1
   } joy_state_e;

endpackage

// File: rtl/pocket_to_snes_map.sv
// Combinational remap of the Pocket key word into SNES serial button order.
module pocket_to_snes_map
   import snes_joypad_pkg::*;
#(
   parameter int unsigned KEY_WIDTH = 16
) (
   input  logic [KEY_WIDTH-1:0]    key,
   output logic [SNES_BUTTONS-1:0] snes
);

   // Pocket bits 10..13 have no SNES counterpart
   logic unused_key;
   assign unused_key = ^key;

   always_comb begin
      snes              = '0;
      snes[SNES_B]      = key[KEY_B];
      snes[SNES_Y]      = key[KEY_Y];
      snes[SNES_SELECT] = key[KEY_SELECT];
      snes[SNES_START]  = key[KEY_START];
      snes[SNES_UP]     = key[KEY_UP];
      snes[SNES_DOWN]   = key[KEY_DOWN];
      snes[SNES_LEFT]   = key[KEY_LEFT];
      snes[SNES_RIGHT]  = key[KEY_RIGHT];
      snes[SNES_A]      = key[KEY_A];
      snes[SNES_X]      = key[KEY_X];
      snes[SNES_L]      = key[KEY_L];
      snes[SNES_R]      = key[KEY_R];
   end

endmodule

// File: rtl/snes_joypad_serializer.sv
// Holds the latest Pocket key state and serves it to the SNES joypad port.
// Optional turbo (per-button auto-release) enabled by SNES_JOYPAD_TURBO_EN.
module snes_joypad_serializer
   import snes_joypad_pkg::*;
#(
   parameter int unsigned KEY_WIDTH = 16,
   parameter logic        FILL_BIT  = 1'b1,
   parameter int unsigned TURBO_DIV = 2
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    key_valid,
   input  logic [KEY_WIDTH-1:0]    key_data,
   input  logic                    joy_latch,
   input  logic                    joy_clk,
`ifdef SNES_JOYPAD_TURBO_EN
   input  logic [SNES_BUTTONS-1:0] turbo_mask,
`endif
   output logic                    joy_data,
   output logic [SNES_BUTTONS-1:0] buttons
);

   localparam int unsigned      CNT_W    = 5;
   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(SNES_SERIAL_BITS);

   logic [SNES_BUTTONS-1:0]     mapped;
   logic [SNES_BUTTONS-1:0]     src;
   logic [SNES_SERIAL_BITS-1:0] shift_q, shift_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic                        clk_q;
   logic                        clk_rise;
   // registered latch level; also serves as the latch edge detector
   joy_state_e                  state_q;

   pocket_to_snes_map #(
      .KEY_WIDTH(KEY_WIDTH)
   ) u_map (
      .key (key_data),
      .snes(mapped)
   );

   assign clk_rise = joy_clk & ~clk_q;

`ifdef SNES_JOYPAD_TURBO_EN
   localparam int unsigned TCNT_W = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;

   logic [TCNT_W-1:0] tcnt_q;
   logic              phase_q;
   logic              latch_fall;

   assign latch_fall = (state_q == ST_LOAD) && !joy_latch;
   assign src = (key_valid ? mapped : buttons) & ~(turbo_mask & {SNES_BUTTONS{phase_q}});

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tcnt_q  <= '0;
         phase_q <= 1'b0;
      end else if (latch_fall) begin
         if (32'(tcnt_q) >= TURBO_DIV - 1) begin
            tcnt_q  <= '0;
            phase_q <= ~phase_q;
         end else begin
            tcnt_q <= tcnt_q + TCNT_W'(1);
         end
      end
   end
`else
   logic unused_state;
   assign unused_state = (state_q == ST_LOAD);
   assign src = key_valid ? mapped : buttons;
`endif

   // Latch level has priority, so a clock edge coinciding with it is dropped
   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      if (joy_latch) begin
         shift_d = {{(SNES_SERIAL_BITS - SNES_BUTTONS){1'b0}}, src};
         cnt_d   = '0;
      end else if (clk_rise && (cnt_q < CNT_DONE)) begin
         shift_d = shift_q >> 1;
         cnt_d   = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= ST_SHIFT;
         clk_q    <= 1'b0;
         shift_q  <= '0;
         cnt_q    <= CNT_DONE;
         joy_data <= FILL_BIT;
         buttons  <= '0;
      end else begin
         state_q  <= joy_latch ? ST_LOAD : ST_SHIFT;
         clk_q    <= joy_clk;
         shift_q  <= shift_d;
         cnt_q    <= cnt_d;
         joy_data <= (cnt_d < CNT_DONE) ? shift_d[0] : FILL_BIT;
         if (key_valid) begin
            buttons <= mapped;
         end
      end
   end

endmodule
